// File: rtl/cpu_types_pkg.sv
// Shared types for the MEM/WB portion of the pipelined core.
//   word_t      : datapath word
//   regbits_t   : register-file index
//   memtoreg_t  : writeback source select
//   mem_state_t : memory-stage handshake state
//   mem_wb_t    : packed MEM/WB pipeline register contents
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REGB_W = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REGB_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    MTR_JAL   = 2'd0,
    MTR_ALU   = 2'd1,
    MTR_DLOAD = 2'd2,
    MTR_LUI   = 2'd3
  } memtoreg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic      valid;
    logic      halt;
    logic      regwrite;
    regbits_t  wsel;
    memtoreg_t memtoreg;
    word_t     jal;
    word_t     aluout;
    word_t     dload;
    word_t     shiftedimm;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
//   CLK    : core clock
//   nRST   : asynchronous active-low reset, clears every field
//   en     : load d into q
//   bubble : clear valid/regwrite (applied after en, so it also squashes a fresh load)
//   d, q   : register contents
module mem_wb_reg
  import cpu_types_pkg::*;
(
  input  logic    CLK,
  input  logic    nRST,
  input  logic    en,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q <= '0;
    end else begin
      if (en) begin
        q <= d;
      end
      if (bubble) begin
        q.valid    <= 1'b0;
        q.regwrite <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage + MEM/WB pipeline register.
// Drives the data-cache request from the EX/MEM fields, stalls the pipe until dhit and
// registers the writeback sources for the WB mux. A bubble goes into WB while an access is
// outstanding. halt becomes sticky the cycle after a valid halt instruction sits in WB.
// Ports:
//   CLK, nRST                    clock, asynchronous active-low reset
//   mem_*                        EX/MEM fields of the instruction in this stage
//   dhit, dmemload               cache completion and load data
//   dmemREN/WEN/addr/store       cache request (combinational)
//   mem_stall                    hold upstream pipeline registers this cycle
//   wb_*                         registered MEM/WB fields
//   halt                         sticky core-halted flag
//   stall_cycles                 saturating count of stalled cycles (MEMWB_STALL_CNT_EN only)
// Build option: define MEMWB_STALL_CNT_EN to add the stall_cycles port and counter.
module mem_wb_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_jal,
  input  logic [DATA_W-1:0] mem_aluOut,
  input  logic [DATA_W-1:0] mem_shiftedImm,
  input  logic [DATA_W-1:0] mem_storeData,
  input  logic [1:0]        mem_memToReg,
  input  logic              mem_regWrite,
  input  logic [REG_AW-1:0] mem_wsel,
  input  logic              mem_memRead,
  input  logic              mem_memWrite,
  input  logic              mem_halt,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic              wb_regWrite,
  output logic [REG_AW-1:0] wb_wsel,
  output logic [1:0]        wb_memToReg,
  output logic [DATA_W-1:0] wb_jal,
  output logic [DATA_W-1:0] wb_aluOut,
  output logic [DATA_W-1:0] wb_dload,
  output logic [DATA_W-1:0] wb_shiftedImm,
  output logic              halt
`ifdef MEMWB_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  mem_state_t state;
  logic       halt_q;
  logic       retire_halt;
  logic       halting;
  logic       req;
  mem_wb_t    wb_d;
  mem_wb_t    wb_q;

  // A halt sitting valid in WB already counts as halting: the instruction behind it must not
  // touch memory or retire, even though the sticky flag only rises on the next edge.
  assign retire_halt = wb_q.valid & wb_q.halt;
  assign halting     = halt_q | retire_halt;

  // nRST gates the request so it drops the instant reset asserts, even mid-access.
  assign req       = nRST & mem_valid & (mem_memRead | mem_memWrite) & ~halting;
  assign dmemREN   = req & mem_memRead;
  assign dmemWEN   = req & mem_memWrite & ~mem_memRead;
  assign dmemaddr  = mem_aluOut[ADDR_W-1:0];
  assign dmemstore = mem_storeData;
  assign mem_stall = req & ~dhit;

  always_comb begin
    wb_d            = '0;
    wb_d.valid      = mem_valid;
    wb_d.halt       = mem_valid & mem_halt;
    wb_d.regwrite   = mem_valid & mem_regWrite;
    wb_d.wsel       = mem_wsel;
    wb_d.memtoreg   = memtoreg_t'(mem_memToReg);
    wb_d.jal        = mem_jal;
    wb_d.aluout     = mem_aluOut;
    wb_d.dload      = (dmemREN & dhit) ? dmemload : '0;
    wb_d.shiftedimm = mem_shiftedImm;
  end

  mem_wb_reg u_mem_wb_reg (
    .CLK    (CLK),
    .nRST   (nRST),
    .en     (~mem_stall),
    .bubble (mem_stall | halting),
    .d      (wb_d),
    .q      (wb_q)
  );

  // Handshake FSM; HALTED is terminal until reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      halt_q <= 1'b0;
    end else if (retire_halt || state == HALTED) begin
      state  <= HALTED;
      halt_q <= 1'b1;
    end else begin
      case (state)
        IDLE:    if (req && !dhit) state <= ACCESS;
        ACCESS:  if (dhit) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign halt          = halt_q;
  assign wb_valid      = wb_q.valid;
  assign wb_regWrite   = wb_q.regwrite;
  assign wb_wsel       = wb_q.wsel;
  assign wb_memToReg   = wb_q.memtoreg;
  assign wb_jal        = wb_q.jal;
  assign wb_aluOut     = wb_q.aluout;
  assign wb_dload      = wb_q.dload;
  assign wb_shiftedImm = wb_q.shiftedimm;

`ifdef MEMWB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
    end else if (mem_stall && !halt_q && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: each issued instruction pushes its expected WB record,
// a negedge monitor pops and compares whenever wb_valid is seen.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        mem_valid;
  logic [31:0] mem_jal, mem_aluOut, mem_shiftedImm, mem_storeData;
  logic [1:0]  mem_memToReg;
  logic        mem_regWrite;
  logic [4:0]  mem_wsel;
  logic        mem_memRead, mem_memWrite, mem_halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        mem_stall;
  logic        wb_valid, wb_regWrite;
  logic [4:0]  wb_wsel;
  logic [1:0]  wb_memToReg;
  logic [31:0] wb_jal, wb_aluOut, wb_dload, wb_shiftedImm;
  logic        halt;
`ifdef MEMWB_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] cnt0;
`endif

  mem_wb_stage dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .mem_valid      (mem_valid),
    .mem_jal        (mem_jal),
    .mem_aluOut     (mem_aluOut),
    .mem_shiftedImm (mem_shiftedImm),
    .mem_storeData  (mem_storeData),
    .mem_memToReg   (mem_memToReg),
    .mem_regWrite   (mem_regWrite),
    .mem_wsel       (mem_wsel),
    .mem_memRead    (mem_memRead),
    .mem_memWrite   (mem_memWrite),
    .mem_halt       (mem_halt),
    .dhit           (dhit),
    .dmemload       (dmemload),
    .dmemREN        (dmemREN),
    .dmemWEN        (dmemWEN),
    .dmemaddr       (dmemaddr),
    .dmemstore      (dmemstore),
    .mem_stall      (mem_stall),
    .wb_valid       (wb_valid),
    .wb_regWrite    (wb_regWrite),
    .wb_wsel        (wb_wsel),
    .wb_memToReg    (wb_memToReg),
    .wb_jal         (wb_jal),
    .wb_aluOut      (wb_aluOut),
    .wb_dload       (wb_dload),
    .wb_shiftedImm  (wb_shiftedImm),
    .halt           (halt)
`ifdef MEMWB_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        regwrite;
    logic [4:0]  wsel;
    logic [1:0]  mtr;
    logic [31:0] jal;
    logic [31:0] alu;
    logic [31:0] dload;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, expv, $time);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (nRST === 1'b1 && wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("wb_unexpected", {31'd0, wb_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("wb_regWrite", {31'd0, wb_regWrite}, {31'd0, e.regwrite});
        check_eq("wb_wsel", {27'd0, wb_wsel}, {27'd0, e.wsel});
        check_eq("wb_memToReg", {30'd0, wb_memToReg}, {30'd0, e.mtr});
        check_eq("wb_jal", wb_jal, e.jal);
        check_eq("wb_aluOut", wb_aluOut, e.alu);
        check_eq("wb_dload", wb_dload, e.dload);
        check_eq("wb_shiftedImm", wb_shiftedImm, e.imm);
      end
    end
  end

  task automatic idle();
    mem_valid = 0; mem_jal = '0; mem_aluOut = '0; mem_shiftedImm = '0; mem_storeData = '0;
    mem_memToReg = '0; mem_regWrite = 0; mem_wsel = '0; mem_memRead = 0; mem_memWrite = 0;
    mem_halt = 0; dhit = 0; dmemload = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    check_eq({tag, "_wb_regWrite"}, {31'd0, wb_regWrite}, 32'd0);
    check_eq({tag, "_wb_wsel"}, {27'd0, wb_wsel}, 32'd0);
    check_eq({tag, "_wb_memToReg"}, {30'd0, wb_memToReg}, 32'd0);
    check_eq({tag, "_wb_jal"}, wb_jal, 32'd0);
    check_eq({tag, "_wb_aluOut"}, wb_aluOut, 32'd0);
    check_eq({tag, "_wb_dload"}, wb_dload, 32'd0);
    check_eq({tag, "_wb_shiftedImm"}, wb_shiftedImm, 32'd0);
    check_eq({tag, "_dmemREN"}, {31'd0, dmemREN}, 32'd0);
    check_eq({tag, "_dmemWEN"}, {31'd0, dmemWEN}, 32'd0);
    check_eq({tag, "_halt"}, {31'd0, halt}, 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction has left MEM.
  task automatic issue(input logic rd, input logic wr, input logic hlt, input logic rw,
                       input logic [1:0] mtr, input logic [4:0] ws, input logic [31:0] jal,
                       input logic [31:0] alu, input logic [31:0] imm, input logic [31:0] sd,
                       input logic [31:0] ld, input int waits);
    exp_t e;
    mem_valid = 1; mem_memRead = rd; mem_memWrite = wr; mem_halt = hlt; mem_regWrite = rw;
    mem_memToReg = mtr; mem_wsel = ws; mem_jal = jal; mem_aluOut = alu;
    mem_shiftedImm = imm; mem_storeData = sd; dhit = 0; dmemload = 32'h0BAD_0BAD;
    for (int i = 0; i < waits; i++) begin
      @(negedge CLK);
      check_eq("stall_wait", {31'd0, mem_stall}, 32'd1);
      check_eq("ren_wait", {31'd0, dmemREN}, {31'd0, rd});
      check_eq("wen_wait", {31'd0, dmemWEN}, {31'd0, wr & ~rd});
      if (i > 0) check_eq("bubble_wb_valid", {31'd0, wb_valid}, 32'd0);
      @(posedge CLK); #1;
    end
    dhit = rd | wr;
    dmemload = ld;
    @(negedge CLK);
    check_eq("stall_done", {31'd0, mem_stall}, 32'd0);
    check_eq("ren", {31'd0, dmemREN}, {31'd0, rd});
    check_eq("wen", {31'd0, dmemWEN}, {31'd0, wr & ~rd});
    if (rd | wr) begin
      check_eq("dmemaddr", dmemaddr, alu);
      check_eq("dmemstore", dmemstore, sd);
    end
    e.regwrite = rw; e.wsel = ws; e.mtr = mtr; e.jal = jal; e.alu = alu;
    e.dload = rd ? ld : 32'h0; e.imm = imm;
    sb.push_back(e);
    @(posedge CLK); #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    nRST = 0;
    #2;
    check_reset_outputs("por");
    @(negedge CLK); nRST = 1;
    @(posedge CLK); #1;

    // jal: rd/wr=0, writes r31 with return address
    issue(0, 0, 0, 1, 2'd0, 5'd31, 32'h0000_0404, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 0);
    // sw zero-wait: no stall, no regwrite
    issue(0, 1, 0, 0, 2'd1, 5'd0, 32'h0, 32'h0000_0040, 32'h0, 32'h0000_1234, 32'h0, 0);
    // lw with three wait cycles
    issue(1, 0, 0, 1, 2'd2, 5'd5, 32'h0, 32'h0000_0100, 32'h0, 32'h0, 32'hDEAD_BEEF, 3);
    // lui, back to back
    issue(0, 0, 0, 1, 2'd3, 5'd7, 32'h0, 32'h1, 32'h1234_0000, 32'h0, 32'h0, 0);
    // read and write together: read wins
    issue(1, 1, 0, 1, 2'd2, 5'd9, 32'h0, 32'h0000_0080, 32'h0, 32'h5555, 32'hCAFE_F00D, 1);

`ifdef MEMWB_STALL_CNT_EN
    cnt0 = stall_cycles;
    issue(1, 0, 0, 1, 2'd2, 5'd3, 32'h0, 32'h0000_0200, 32'h0, 32'h0, 32'h1111_2222, 2);
    issue(1, 0, 0, 1, 2'd2, 5'd4, 32'h0, 32'h0000_0204, 32'h0, 32'h0, 32'h3333_4444, 2);
    check_eq("stall_cycles_delta", stall_cycles - cnt0, 32'd4);
`endif

    // halt followed by lw: lw never requests, nothing further retires
    issue(0, 0, 1, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    mem_valid = 1; mem_memRead = 1; mem_regWrite = 1; mem_memToReg = 2'd2;
    mem_aluOut = 32'h0000_0300; mem_wsel = 5'd6; dhit = 0;
    @(negedge CLK);
    check_eq("halt_next_ren", {31'd0, dmemREN}, 32'd0);
    check_eq("halt_next_stall", {31'd0, mem_stall}, 32'd0);
    check_eq("halt_not_yet", {31'd0, halt}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      dhit = 1;
      @(negedge CLK);
      check_eq("halted", {31'd0, halt}, 32'd1);
      check_eq("halted_ren", {31'd0, dmemREN}, 32'd0);
      check_eq("halted_wb_valid", {31'd0, wb_valid}, 32'd0);
    end
    @(posedge CLK); #1;
    idle();
    nRST = 0;
    #1;
    check_eq("halt_cleared", {31'd0, halt}, 32'd0);
    #1 nRST = 1;
    @(posedge CLK); #1;

    // reset in the middle of an outstanding access
    issue(0, 0, 0, 1, 2'd0, 5'd31, 32'h0000_0808, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    mem_valid = 1; mem_memRead = 1; mem_regWrite = 1; mem_memToReg = 2'd2;
    mem_aluOut = 32'h0000_0300; mem_wsel = 5'd8; dhit = 0;
    @(negedge CLK);
    check_eq("access_stall", {31'd0, mem_stall}, 32'd1);
    check_eq("access_ren", {31'd0, dmemREN}, 32'd1);
    @(posedge CLK); #1;
    nRST = 0;
    #1;
    check_reset_outputs("mid_access");
    check_eq("mid_access_stall", {31'd0, mem_stall}, 32'd0);
    dhit = 1; dmemload = 32'hFFFF_FFFF;
    @(negedge CLK);
    check_eq("in_reset_wb_dload", wb_dload, 32'd0);
    idle();
    nRST = 1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check_eq("after_reset_wb_valid", {31'd0, wb_valid}, 32'd0);

    repeat (2) @(posedge CLK);
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
